jtldtest_pattern: RTL and testbench



---
 rtl/jtldtest_pkg.sv | 23 ++
 rtl/jtldtest_lfsr.sv | 37 +++
 rtl/jtldtest_pattern.sv | 169 ++++++++++++++++
 tb/tb_jtldtest_pattern.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtldtest_pkg.sv
// Shared definitions for the SDRAM load-test pattern generator: FSM encoding,
// LFSR feedback constant and default seed.
package jtldtest_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRPASS  = 3'd1,
    GAP1    = 3'd2,
    CHKPASS = 3'd3,
    GAP2    = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois step, shift right; feedback applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] sh;
    sh = {1'b0, v[15:1]};
    return v[0] ? (sh ^ LFSR_TAPS) : sh;
  endfunction

endpackage

// File: rtl/jtldtest_lfsr.sv
// 16-bit Galois LFSR; load has priority over adv, both take effect on the next edge.
module jtldtest_lfsr
  import jtldtest_pkg::*;
#(
  parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (adv) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RST_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/jtldtest_pattern.sv
// Host-free download-stream source: a write pass then an identical check pass,
// one strobe per WR_GAP cycles, optional single-byte corruption in the check pass.
module jtldtest_pattern
  import jtldtest_pkg::*;
#(
  parameter int unsigned LEN      = 32'h0200_0000,
  parameter int unsigned WR_GAP   = 8,
  parameter int unsigned PASS_GAP = 64,
  parameter logic [15:0] SEED     = DEFAULT_SEED,
  parameter logic [24:0] ERR_ADDR = 25'h080_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        inject_err,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        downloading,
  output logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_dout,
  output logic        ioctl_wr
);

  localparam int unsigned   MAX_GAP   = (WR_GAP > PASS_GAP) ? WR_GAP : PASS_GAP;
  localparam int            CW        = $clog2(MAX_GAP);
  localparam logic [CW-1:0] WR_LAST   = CW'(WR_GAP - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(PASS_GAP - 1);
  localparam logic [24:0]   LAST_ADDR = 25'(LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          inj_q, inj_d;
  logic          last_q, last_d;

  logic          lfsr_load;
  logic          lfsr_adv;
  logic [15:0]   lfsr_q;
  logic          upd;
  logic [7:0]    byte_nx;

  jtldtest_lfsr #(
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED),
    .adv   (lfsr_adv),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    addr_d    = addr_q;
    dout_d    = dout_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    inj_d     = inj_q;
    last_d    = last_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    upd       = 1'b0;
    byte_nx   = 8'h00;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A start landing on the done cycle belongs to the run just finished.
        if (start && !done_q) begin
          state_d   = WRPASS;
          inj_d     = inject_err;
          addr_d    = '0;
          last_d    = 1'b0;
          lfsr_load = 1'b1;
          upd       = 1'b1;
          byte_nx   = SEED[7:0];
        end
      end

      WRPASS, CHKPASS: begin
        if (cnt_q == WR_LAST) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = (state_q == WRPASS) ? GAP1 : GAP2;
          end else begin
            wr_d = 1'b1;
            if (addr_q == LAST_ADDR) begin
              last_d = 1'b1;
            end
          end
        end
        // The final address is held, so LEN = 2^25 never wraps back to 0.
        if (wr_q && !last_q) begin
          addr_d   = addr_q + 25'd1;
          lfsr_adv = 1'b1;
          upd      = 1'b1;
          byte_nx  = 8'(lfsr_next(lfsr_q));
        end
      end

      GAP1: begin
        if (cnt_q == GAP_LAST) begin
          state_d   = CHKPASS;
          cnt_d     = '0;
          addr_d    = '0;
          last_d    = 1'b0;
          lfsr_load = 1'b1;
          upd       = 1'b1;
          byte_nx   = SEED[7:0];
        end
      end

      GAP2: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Corruption only touches the presented byte; the LFSR keeps its sequence.
    if (upd) begin
      dout_d = byte_nx ^ {8{inj_d && (state_d == CHKPASS) && (addr_d == ERR_ADDR)}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      inj_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      inj_q   <= inj_d;
      last_q  <= last_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign pass        = (state_q inside {CHKPASS, GAP2});
  assign downloading = (state_q inside {WRPASS, CHKPASS});
  assign done        = done_q;
  assign ioctl_addr  = addr_q;
  assign ioctl_dout  = dout_q;
  assign ioctl_wr    = wr_q;

endmodule

// File: tb/tb_jtldtest_pattern.sv
// Directed bench: LEN=16/WR_GAP=4/PASS_GAP=8 instance plus a LEN=1 instance,
// strobes recorded on the falling edge relative to the rise of busy.
module tb_jtldtest_pattern;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        inject_err = 1'b0;
  logic        busy, done, pass, downloading, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        start_b = 1'b0;
  logic        inject_b = 1'b0;
  logic        busy_b, done_b, pass_b, dl_b, wr_b;
  logic [24:0] addr_b;
  logic [7:0]  dout_b;

  always #5 clk = ~clk;

  jtldtest_pattern #(
    .LEN(16), .WR_GAP(4), .PASS_GAP(8), .SEED(16'hACE1), .ERR_ADDR(25'd5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inject_err(inject_err),
    .busy(busy), .done(done), .pass(pass), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr)
  );

  jtldtest_pattern #(
    .LEN(1), .WR_GAP(4), .PASS_GAP(8), .SEED(16'hACE1), .ERR_ADDR(25'd5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .inject_err(inject_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .downloading(dl_b),
    .ioctl_addr(addr_b), .ioctl_dout(dout_b), .ioctl_wr(wr_b)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_byte [16];

  // Recorder for the LEN=16 instance; cycle 0 is the first cycle busy is high.
  int          cyc = 0, nrec = 0, done_cyc = -1, done_cnt = 0, dl0 = 0, dl1 = 0, wr_off = 0;
  logic        busy_p = 1'b0;
  logic [24:0] r_addr [64];
  logic [7:0]  r_dat  [64];
  int          r_cyc  [64];
  logic        r_pass [64];

  always @(negedge clk) begin
    if (busy && !busy_p) begin
      cyc = 0; nrec = 0; done_cyc = -1; dl0 = 0; dl1 = 0;
    end else begin
      cyc++;
    end
    busy_p = busy;
    if (ioctl_wr && nrec < 64) begin
      r_addr[nrec] = ioctl_addr; r_dat[nrec] = ioctl_dout;
      r_cyc[nrec] = cyc; r_pass[nrec] = pass; nrec++;
    end
    if (ioctl_wr && !downloading) wr_off++;
    if (downloading) begin
      if (pass) dl1++; else dl0++;
    end
    if (done) begin done_cyc = cyc; done_cnt++; end
  end

  int          cyc_b = 0, nrec_b = 0, done_cyc_b = -1, dl0_b = 0, dl1_b = 0;
  logic        busy_bp = 1'b0;
  logic [24:0] rb_addr [8];
  logic [7:0]  rb_dat  [8];

  always @(negedge clk) begin
    if (busy_b && !busy_bp) begin
      cyc_b = 0; nrec_b = 0; done_cyc_b = -1; dl0_b = 0; dl1_b = 0;
    end else begin
      cyc_b++;
    end
    busy_bp = busy_b;
    if (wr_b && nrec_b < 8) begin
      rb_addr[nrec_b] = addr_b; rb_dat[nrec_b] = dout_b; nrec_b++;
    end
    if (dl_b) begin
      if (pass_b) dl1_b++; else dl0_b++;
    end
    if (done_b) done_cyc_b = cyc_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic inj);
    inject_err = inj;
    start = 1'b1;
    step();
    start = 1'b0;
    inject_err = 1'b0;
    step();
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (done_cyc < 0 && n < 400) begin step(); n++; end
    total++;
    if (done_cyc < 0) begin
      bad++; $display("FAIL %s done_timeout: no done within %0d cycles", tag, n);
    end
  endtask

  task automatic test_reset();
    step(); step();
    total++;
    if ({busy, done, pass, downloading, ioctl_addr, ioctl_dout, ioctl_wr} !== 37'd0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b done=%b pass=%b dl=%b addr=%h dout=%h wr=%b want all 0",
                      busy, done, pass, downloading, ioctl_addr, ioctl_dout, ioctl_wr);
    end
    rst_n = 1'b1;
    step(); step();
    total++;
    if ({busy, done, pass, downloading, ioctl_wr, busy_b, dl_b, wr_b} !== 8'd0) begin
      bad++; $display("FAIL post_reset_idle: got busy=%b dl=%b wr=%b busy_b=%b want 0",
                      busy, downloading, ioctl_wr, busy_b);
    end
  endtask

  task automatic test_first_writes();
    logic [7:0] hand [3];
    hand[0] = 8'hE1; hand[1] = 8'h70; hand[2] = 8'h38;
    pulse_start(1'b0);
    total++;
    if (busy !== 1'b1 || downloading !== 1'b1 || ioctl_dout !== 8'hE1 || ioctl_addr !== 25'd0) begin
      bad++; $display("FAIL start_latency: got busy=%b dl=%b addr=%h dout=%h want 1 1 0 e1",
                      busy, downloading, ioctl_addr, ioctl_dout);
    end
    wait_done_a("first_writes");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (r_addr[k] !== 25'(k) || r_dat[k] !== hand[k] || r_cyc[k] != 4 * (k + 1)) begin
        bad++; $display("FAIL first_write%0d: got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                        k, r_addr[k], r_dat[k], r_cyc[k], k, hand[k], 4 * (k + 1));
      end
    end
  endtask

  task automatic test_full_run();
    pulse_start(1'b0);
    wait_done_a("full_run");
    total++;
    if (nrec != 32) begin bad++; $display("FAIL full_strobes: got %0d want 32", nrec); end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (r_addr[k] !== 25'(k) || r_dat[k] !== exp_byte[k] || r_pass[k] !== 1'b0 || r_cyc[k] != 4 * (k + 1)) begin
        bad++; $display("FAIL wr_pass%0d: got addr=%0d data=%h pass=%b cyc=%0d want %0d %h 0 %0d",
                        k, r_addr[k], r_dat[k], r_pass[k], r_cyc[k], k, exp_byte[k], 4 * (k + 1));
      end
      total++;
      if (r_addr[16+k] !== 25'(k) || r_dat[16+k] !== exp_byte[k] || r_pass[16+k] !== 1'b1 ||
          r_cyc[16+k] != 76 + 4 * (k + 1)) begin
        bad++; $display("FAIL chk_pass%0d: got addr=%0d data=%h pass=%b cyc=%0d want %0d %h 1 %0d",
                        k, r_addr[16+k], r_dat[16+k], r_pass[16+k], r_cyc[16+k], k, exp_byte[k], 76 + 4 * (k + 1));
      end
    end
    total++;
    if (dl0 != 68 || dl1 != 68) begin
      bad++; $display("FAIL dl_cycles: got %0d/%0d want 68/68", dl0, dl1);
    end
    total++;
    if (done_cyc != 152) begin bad++; $display("FAIL done_time: got %0d want 152", done_cyc); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_done: got %b want 0", busy); end
  endtask

  task automatic test_inject();
    logic [7:0] want;
    pulse_start(1'b1);
    wait_done_a("inject");
    total++;
    if (nrec != 32) begin bad++; $display("FAIL inj_strobes: got %0d want 32", nrec); end
    for (int k = 0; k < 16; k++) begin
      want = (k == 5) ? ~exp_byte[k] : exp_byte[k];
      total++;
      if (r_dat[k] !== exp_byte[k] || r_dat[16+k] !== want) begin
        bad++; $display("FAIL inject_byte%0d: got wr=%h chk=%h want wr=%h chk=%h",
                        k, r_dat[k], r_dat[16+k], exp_byte[k], want);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    pulse_start(1'b0);
    while (!(pass && downloading) && n < 200) begin step(); n++; end
    total++;
    if (!(pass && downloading)) begin bad++; $display("FAIL reach_chkpass: got pass=%b want 1", pass); end
    pulse_start(1'b1);
    wait_done_a("ignored_start");
    total++;
    if (nrec != 32 || done_cyc != 152 || r_dat[21] !== exp_byte[5]) begin
      bad++; $display("FAIL start_in_chk: got strobes=%0d done=%0d byte5=%h want 32 152 %h",
                      nrec, done_cyc, r_dat[21], exp_byte[5]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    pulse_start(1'b0);
    while (done !== 1'b1 && n < 400) begin step(); n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
    start = 1'b1;
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL start_on_done: got busy=%b want 0", busy); end
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_after_done: got busy=%b want 1", busy); end
    step();
    wait_done_a("b2b");
    total++;
    if (done_cyc != 152 || nrec != 32) begin
      bad++; $display("FAIL b2b_run: got done=%0d strobes=%0d want 152 32", done_cyc, nrec);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    int dc;
    pulse_start(1'b0);
    while (!(downloading && ioctl_addr == 25'd7) && n < 100) begin step(); n++; end
    total++;
    if (ioctl_addr !== 25'd7) begin bad++; $display("FAIL reach_addr7: got %0d want 7", ioctl_addr); end
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, pass, downloading, ioctl_addr, ioctl_dout, ioctl_wr} !== 37'd0) begin
      bad++; $display("FAIL async_reset: got busy=%b dl=%b addr=%h dout=%h wr=%b want all 0",
                      busy, downloading, ioctl_addr, ioctl_dout, ioctl_wr);
    end
    step(); step();
    rst_n = 1'b1;
    step(); step();
    total++;
    if (done_cnt != dc || busy !== 1'b0) begin
      bad++; $display("FAIL abort_no_done: got done_pulses=%0d busy=%b want 0 0", done_cnt - dc, busy);
    end
    pulse_start(1'b0);
    total++;
    if (ioctl_addr !== 25'd0 || ioctl_dout !== 8'hE1) begin
      bad++; $display("FAIL replay_entry: got addr=%h dout=%h want 0 e1", ioctl_addr, ioctl_dout);
    end
    wait_done_a("replay");
    total++;
    if (r_addr[0] !== 25'd0 || r_dat[0] !== 8'hE1 || nrec != 32) begin
      bad++; $display("FAIL replay_first: got addr=%0d data=%h strobes=%0d want 0 e1 32",
                      r_addr[0], r_dat[0], nrec);
    end
  endtask

  task automatic test_len1();
    int n = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    while (done_cyc_b < 0 && n < 100) begin step(); n++; end
    total++;
    if (done_cyc_b != 32) begin bad++; $display("FAIL len1_done: got %0d want 32", done_cyc_b); end
    total++;
    if (nrec_b != 2 || rb_addr[0] !== 25'd0 || rb_addr[1] !== 25'd0 ||
        rb_dat[0] !== 8'hE1 || rb_dat[1] !== 8'hE1) begin
      bad++; $display("FAIL len1_strobes: got n=%0d a=%0d/%0d d=%h/%h want 2 0/0 e1/e1",
                      nrec_b, rb_addr[0], rb_addr[1], rb_dat[0], rb_dat[1]);
    end
    total++;
    if (dl0_b != 8 || dl1_b != 8) begin
      bad++; $display("FAIL len1_dl: got %0d/%0d want 8/8", dl0_b, dl1_b);
    end
  endtask

  initial begin
    logic [15:0] v;
    v = 16'hACE1;
    for (int k = 0; k < 16; k++) begin
      exp_byte[k] = v[7:0];
      v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    end
    test_reset();
    test_first_writes();
    test_full_run();
    test_inject();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_len1();
    total++;
    if (wr_off != 0) begin bad++; $display("FAIL wr_outside_dl: got %0d strobes want 0", wr_off); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
